// File: rtl/pinmux_msc_pkg.sv
// Shared definitions for the MSC configuration receiver.
// Build option: define PINMUX_MSC_PARITY_EN to append an even-parity bit to every frame.
package pinmux_msc_pkg;

`ifdef PINMUX_MSC_PARITY_EN
    localparam int unsigned MSC_PAR_BITS = 1;
`else
    localparam int unsigned MSC_PAR_BITS = 0;
`endif

    // 8 address bits + 16 data bits (+ optional parity bit)
    localparam int unsigned MSC_FRAME_BITS = 24 + MSC_PAR_BITS;
    localparam int unsigned MSC_CNT_W      = 5;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck,
        StOvf
    } msc_state_e;

    localparam logic [7:0] ADDR_PADCTL     = 8'd0;
    localparam logic [7:0] ADDR_INFEN_LO   = 8'd1;
    localparam logic [7:0] ADDR_INFEN_HI   = 8'd2;
    localparam logic [7:0] ADDR_GLITCH_PES = 8'd3;

    // Pad-control word bit positions
    localparam int unsigned PAD_AMSEL      = 15;
    localparam int unsigned PAD_DS0        = 14;
    localparam int unsigned PAD_DS1        = 13;
    localparam int unsigned PAD_SLEW       = 12;
    localparam int unsigned PAD_SCHMITT    = 11;
    localparam int unsigned PAD_MODE0      = 10;
    localparam int unsigned PAD_MODE1      = 9;
    localparam int unsigned PAD_INENA      = 8;
    localparam int unsigned PAD_DIR        = 7;
    localparam int unsigned PAD_PULL_EN    = 6;
    localparam int unsigned PAD_PULL_TYPE  = 5;
    localparam int unsigned PAD_MUXSEL_LSB = 0;

    // Glitch-filter / port-stop word bit positions
    localparam int unsigned GP_DEBOUNCE_LSB = 14;
    localparam int unsigned GP_BYPASS_LSB   = 11;
    localparam int unsigned GP_PES_EN_LSB   = 3;
    localparam int unsigned GP_PES_IN_EN    = 2;
    localparam int unsigned GP_SAFEVAL_LSB  = 0;

endpackage

// File: rtl/msc_shift_rx.sv
// Serial frame capture: shift register, saturating bit counter and running parity.
// Frame length follows PINMUX_MSC_PARITY_EN through the package default.
module msc_shift_rx
    import pinmux_msc_pkg::*;
#(
    parameter int unsigned FRAME_BITS = MSC_FRAME_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift,
    input  logic                 sdi,
    output logic [23:0]          payload,
    output logic [MSC_CNT_W-1:0] count,
    output logic                 parity
);

    logic [FRAME_BITS-1:0] sr_q;
    logic [MSC_CNT_W-1:0]  count_q;
    logic                  parity_q;

    // Capture bits MSB first; clear restarts a frame and may take its first bit at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
        end else if (clear) begin
            count_q  <= shift ? MSC_CNT_W'(1) : '0;
            parity_q <= shift & sdi;
            if (shift) sr_q <= {sr_q[FRAME_BITS-2:0], sdi};
        end else if (shift) begin
            sr_q     <= {sr_q[FRAME_BITS-2:0], sdi};
            parity_q <= parity_q ^ sdi;
            if (count_q != '1) count_q <= count_q + MSC_CNT_W'(1);
        end
    end

    // Address and data sit above the optional trailing parity bit
    assign payload = sr_q[FRAME_BITS-1 -: 24];
    assign count   = count_q;
    assign parity  = parity_q;

endmodule

// File: rtl/pinmux_msc_cfg_rx.sv
// MSC serial configuration receiver: frames of addr/data are validated and written into
// four 16-bit configuration words that drive the pad, input-function and port-stop controls.
// Build option: PINMUX_MSC_PARITY_EN selects 25-bit frames with even parity (24 bits without).
module pinmux_msc_cfg_rx
    import pinmux_msc_pkg::*;
#(
    parameter int unsigned FRAME_BITS = MSC_FRAME_BITS,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_msc_en,
    input  logic        i_msc_bit_vld,
    input  logic        i_msc_sdi,
    output logic        amsel_out_mscbus,
    output logic        ds0_out_mscbus,
    output logic        ds1_out_mscbus,
    output logic        slew_out_mscbus,
    output logic        schmitt_out_mscbus,
    output logic        mode0_out_mscbus,
    output logic        mode1_out_mscbus,
    output logic        inena_out_mscbus,
    output logic        dir_out_mscbus,
    output logic        pull_en_out_mscbus,
    output logic        pull_type_out_mscbus,
    output logic [4:0]  pinmux_muxsel_out_mscbus,
    output logic [31:0] in_function_en_out_mscbus,
    output logic [1:0]  glitch_filter_debounce_clk_sel_out_mscbus,
    output logic [2:0]  glitch_filter_bypass_out_mscbus,
    output logic [7:0]  pes_en_out_mscbus,
    output logic        pes_in_en_out_mscbus,
    output logic [1:0]  pes_safeval_out_mscbus,
    output logic        o_cfg_update,
    output logic        o_frame_err
);

    localparam logic [MSC_CNT_W-1:0] FRAME_LEN = MSC_CNT_W'(FRAME_BITS);

    msc_state_e           state_q;
    logic                 en_q;
    logic [15:0]          padctl_q, infen_lo_q, infen_hi_q, glitch_pes_q;
    logic                 cfg_update_q, frame_err_q;
    logic [23:0]          payload;
    logic [MSC_CNT_W-1:0] count;
    logic                 parity;
    logic                 start, clear, shift, accept, has_bits;
    logic [7:0]           frame_addr;
    logic [15:0]          frame_data;

    msc_shift_rx #(
        .FRAME_BITS(FRAME_BITS)
    ) u_shift_rx (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  (clear),
        .shift  (shift),
        .sdi    (i_msc_sdi),
        .payload(payload),
        .count  (count),
        .parity (parity)
    );

    // Frame start/shift qualification and the CHECK-state acceptance decision
    always_comb begin
        clear      = (state_q == StIdle) || (state_q == StCheck);
        // en may come back during CHECK, so a new frame can start there without an edge
        start      = ((state_q == StIdle) && i_msc_en && !en_q) ||
                     ((state_q == StCheck) && i_msc_en);
        shift      = i_msc_en && i_msc_bit_vld &&
                     ((state_q == StShift) || (state_q == StOvf) || start);
        frame_addr = payload[23:16];
        frame_data = payload[15:0];
        has_bits   = (count != '0);
        accept     = (count == FRAME_LEN) &&
                     ((MSC_PAR_BITS == 0) || !parity) &&
                     (32'(frame_addr) < NUM_REGS);
    end

    // en history follows the pin even in reset so a held en never looks like a new edge
    always_ff @(posedge i_clk) begin
        en_q <= i_msc_en;
    end

    // Frame FSM with registered commit of the target word and one-cycle status pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            padctl_q     <= '0;
            infen_lo_q   <= '0;
            infen_hi_q   <= '0;
            glitch_pes_q <= '0;
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) state_q <= StShift;
                end
                StShift: begin
                    if (!i_msc_en)              state_q <= StCheck;
                    else if (count > FRAME_LEN) state_q <= StOvf;
                end
                StOvf: begin
                    if (!i_msc_en) state_q <= StCheck;
                end
                StCheck: begin
                    state_q <= i_msc_en ? StShift : StIdle;
                    if (accept) begin
                        cfg_update_q <= 1'b1;
                        case (frame_addr)
                            ADDR_PADCTL:     padctl_q     <= frame_data;
                            ADDR_INFEN_LO:   infen_lo_q   <= frame_data;
                            ADDR_INFEN_HI:   infen_hi_q   <= frame_data;
                            ADDR_GLITCH_PES: glitch_pes_q <= frame_data;
                            default: ;
                        endcase
                    end else if (has_bits) begin
                        // an empty en pulse is dropped silently
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign amsel_out_mscbus     = padctl_q[PAD_AMSEL];
    assign ds0_out_mscbus       = padctl_q[PAD_DS0];
    assign ds1_out_mscbus       = padctl_q[PAD_DS1];
    assign slew_out_mscbus      = padctl_q[PAD_SLEW];
    assign schmitt_out_mscbus   = padctl_q[PAD_SCHMITT];
    assign mode0_out_mscbus     = padctl_q[PAD_MODE0];
    assign mode1_out_mscbus     = padctl_q[PAD_MODE1];
    assign inena_out_mscbus     = padctl_q[PAD_INENA];
    assign dir_out_mscbus       = padctl_q[PAD_DIR];
    assign pull_en_out_mscbus   = padctl_q[PAD_PULL_EN];
    assign pull_type_out_mscbus = padctl_q[PAD_PULL_TYPE];
    assign pinmux_muxsel_out_mscbus  = padctl_q[PAD_MUXSEL_LSB +: 5];
    assign in_function_en_out_mscbus = {infen_hi_q, infen_lo_q};
    assign glitch_filter_debounce_clk_sel_out_mscbus = glitch_pes_q[GP_DEBOUNCE_LSB +: 2];
    assign glitch_filter_bypass_out_mscbus           = glitch_pes_q[GP_BYPASS_LSB +: 3];
    assign pes_en_out_mscbus      = glitch_pes_q[GP_PES_EN_LSB +: 8];
    assign pes_in_en_out_mscbus   = glitch_pes_q[GP_PES_IN_EN];
    assign pes_safeval_out_mscbus = glitch_pes_q[GP_SAFEVAL_LSB +: 2];
    assign o_cfg_update = cfg_update_q;
    assign o_frame_err  = frame_err_q;

endmodule
